// File: rtl/ama_riscv_csr_pkg.sv
// Shared CSR definitions: address map, operation encoding and the
// read-only/ALU helpers used by the CSR unit.
package ama_riscv_csr_pkg;

  localparam logic [11:0] CSR_ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_ADDR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_ADDR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_ADDR_TOHOST    = 12'h51E;

  typedef enum logic [1:0] {
    CSR_OP_SEL_NONE = 2'b00,
    CSR_OP_SEL_RW   = 2'b01,
    CSR_OP_SEL_RS   = 2'b10,
    CSR_OP_SEL_RC   = 2'b11
  } csr_op_sel_t;

  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

  function automatic logic [31:0] csr_alu(input csr_op_sel_t op_sel,
                                          input logic [31:0] old_val,
                                          input logic [31:0] operand);
    case (op_sel)
      CSR_OP_SEL_RW: return operand;
      CSR_OP_SEL_RS: return old_val | operand;
      CSR_OP_SEL_RC: return old_val & ~operand;
      default:       return old_val;
    endcase
  endfunction

endpackage

// File: rtl/ama_riscv_csr_if.sv
// Decoder <-> CSR unit control bus; the master is the EX-stage decoder side,
// the slave is the CSR unit.
interface ama_riscv_csr_if;
  logic        csr_en;
  logic        csr_we;
  logic        csr_ui;
  logic [1:0]  csr_op_sel;
  logic [11:0] csr_addr;
  logic [4:0]  csr_uimm;
  logic [31:0] rs1_data;
  logic        stall_ex;
  logic        inst_retired;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] tohost;

  modport master (
    output csr_en, csr_we, csr_ui, csr_op_sel, csr_addr, csr_uimm,
           rs1_data, stall_ex, inst_retired,
    input  csr_rdata, csr_illegal, tohost
  );

  modport slave (
    input  csr_en, csr_we, csr_ui, csr_op_sel, csr_addr, csr_uimm,
           rs1_data, stall_ex, inst_retired,
    output csr_rdata, csr_illegal, tohost
  );
endinterface

// File: rtl/ama_riscv_csr_cnt64.sv
// Split-writable counter: full-width increment, independent 32-bit lo/hi
// writes that override the increment for the half they touch.
module ama_riscv_csr_cnt64 #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    // A write discards this cycle's increment entirely, so the untouched half
    // keeps its pre-increment value and no carry leaks across.
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_d[31:0]       = wdata;
      if (wr_hi) cnt_d[CNT_W-1:32] = wdata[CNT_W-33:0];
    end else if (inc_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_csr.sv
// CSR unit: combinational read/illegal decode in EX, writes commit on the
// EX->MEM edge; holds cycle/instret counters, mscratch and tohost.
module ama_riscv_csr #(
  parameter logic [31:0] RESET_TOHOST = 32'h0,
  parameter int          CNT_W        = 64
) (
  input  logic              clk,
  input  logic              rst,
  ama_riscv_csr_if.slave    csr_bus
);
  import ama_riscv_csr_pkg::*;

  csr_op_sel_t      op_sel;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [31:0]      mscratch_q, mscratch_d;
  logic [31:0]      tohost_q, tohost_d;
  logic [31:0]      old_val, operand, new_val;
  logic             mapped, read_only, wr_en;
  logic             cycle_wr_lo, cycle_wr_hi, instret_wr_lo, instret_wr_hi;

  assign op_sel = csr_op_sel_t'(csr_bus.csr_op_sel);

  always_comb begin
    old_val = '0;
    mapped  = 1'b1;
    case (csr_bus.csr_addr)
      CSR_ADDR_CYCLE, CSR_ADDR_TIME, CSR_ADDR_MCYCLE:
        old_val = cycle_cnt[31:0];
      CSR_ADDR_CYCLEH, CSR_ADDR_TIMEH, CSR_ADDR_MCYCLEH:
        old_val = 32'(cycle_cnt >> 32);
      CSR_ADDR_INSTRET, CSR_ADDR_MINSTRET:
        old_val = instret_cnt[31:0];
      CSR_ADDR_INSTRETH, CSR_ADDR_MINSTRETH:
        old_val = 32'(instret_cnt >> 32);
      CSR_ADDR_MSCRATCH: old_val = mscratch_q;
      CSR_ADDR_TOHOST:   old_val = tohost_q;
      default:           mapped  = 1'b0;
    endcase
  end

  assign operand   = csr_bus.csr_ui ? {27'b0, csr_bus.csr_uimm} : csr_bus.rs1_data;
  assign new_val   = csr_alu(op_sel, old_val, operand);
  assign read_only = csr_is_ro(csr_bus.csr_addr);

  // Reserved op_sel is flagged illegal on any access and never writes.
  assign csr_bus.csr_illegal = !rst && (csr_bus.csr_en || csr_bus.csr_we) &&
                               (!mapped || (csr_bus.csr_we && read_only) ||
                                (op_sel == CSR_OP_SEL_NONE));
  assign csr_bus.csr_rdata   = (!rst && csr_bus.csr_en) ? old_val : 32'h0;
  assign csr_bus.tohost      = tohost_q;

  assign wr_en = csr_bus.csr_we && !csr_bus.stall_ex && mapped && !read_only &&
                 (op_sel != CSR_OP_SEL_NONE);

  assign cycle_wr_lo   = wr_en && (csr_bus.csr_addr == CSR_ADDR_MCYCLE);
  assign cycle_wr_hi   = wr_en && (csr_bus.csr_addr == CSR_ADDR_MCYCLEH);
  assign instret_wr_lo = wr_en && (csr_bus.csr_addr == CSR_ADDR_MINSTRET);
  assign instret_wr_hi = wr_en && (csr_bus.csr_addr == CSR_ADDR_MINSTRETH);

  ama_riscv_csr_cnt64 #(.CNT_W(CNT_W)) u_cycle (
    .clk    (clk),
    .rst    (rst),
    .inc_en (1'b1),
    .wr_lo  (cycle_wr_lo),
    .wr_hi  (cycle_wr_hi),
    .wdata  (new_val),
    .cnt    (cycle_cnt)
  );

  ama_riscv_csr_cnt64 #(.CNT_W(CNT_W)) u_instret (
    .clk    (clk),
    .rst    (rst),
    .inc_en (csr_bus.inst_retired && !csr_bus.stall_ex),
    .wr_lo  (instret_wr_lo),
    .wr_hi  (instret_wr_hi),
    .wdata  (new_val),
    .cnt    (instret_cnt)
  );

  always_comb begin
    mscratch_d = mscratch_q;
    tohost_d   = tohost_q;
    if (wr_en && (csr_bus.csr_addr == CSR_ADDR_MSCRATCH)) mscratch_d = new_val;
    if (wr_en && (csr_bus.csr_addr == CSR_ADDR_TOHOST))   tohost_d   = new_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mscratch_q <= '0;
      tohost_q   <= RESET_TOHOST;
    end else begin
      mscratch_q <= mscratch_d;
      tohost_q   <= tohost_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_csr.sv
// Self-checking bench for ama_riscv_csr: directed literal checks plus a
// randomized run compared every cycle against an architectural CSR model.
module tb_ama_riscv_csr;

  localparam logic [31:0] TB_RESET_TOHOST = 32'hA5A5_0001;
  localparam logic [1:0]  OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  // Architectural state of the model.
  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_mscratch, m_tohost;

  ama_riscv_csr_if bus ();

  ama_riscv_csr #(.RESET_TOHOST(TB_RESET_TOHOST), .CNT_W(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .csr_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // {mapped, value} of a CSR address in the model.
  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'hC00, 12'hC01, 12'hB00: return {1'b1, m_cycle[31:0]};
      12'hC80, 12'hC81, 12'hB80: return {1'b1, m_cycle[63:32]};
      12'hC02, 12'hB02:          return {1'b1, m_instret[31:0]};
      12'hC82, 12'hB82:          return {1'b1, m_instret[63:32]};
      12'h340:                   return {1'b1, m_mscratch};
      12'h51E:                   return {1'b1, m_tohost};
      default:                   return 33'h0;
    endcase
  endfunction

  // Model update on each clock edge from the inputs presented in that cycle.
  always @(posedge clk) begin
    logic [32:0] rv;
    logic [31:0] opnd, nv;
    logic [63:0] nc, ni;
    logic        commit;
    if (rst) begin
      m_cycle    = 64'h0;
      m_instret  = 64'h0;
      m_mscratch = 32'h0;
      m_tohost   = TB_RESET_TOHOST;
    end else begin
      rv     = m_read(bus.csr_addr);
      opnd   = bus.csr_ui ? {27'b0, bus.csr_uimm} : bus.rs1_data;
      nv     = (bus.csr_op_sel == OP_RW) ? opnd :
               (bus.csr_op_sel == OP_RS) ? (rv[31:0] | opnd) : (rv[31:0] & ~opnd);
      commit = bus.csr_we && !bus.stall_ex && rv[32] &&
               (bus.csr_addr[11:10] != 2'b11) && (bus.csr_op_sel != 2'b00);
      nc = m_cycle + 64'd1;
      ni = m_instret + ((bus.inst_retired && !bus.stall_ex) ? 64'd1 : 64'd0);
      if (commit) begin
        case (bus.csr_addr)
          12'hB00: nc = {m_cycle[63:32], nv};
          12'hB80: nc = {nv, m_cycle[31:0]};
          12'hB02: ni = {m_instret[63:32], nv};
          12'hB82: ni = {nv, m_instret[31:0]};
          12'h340: m_mscratch = nv;
          12'h51E: m_tohost = nv;
          default: ;
        endcase
      end
      m_cycle   = nc;
      m_instret = ni;
    end
  end

  // Compare process: outputs are meaningful every cycle.
  always @(negedge clk) begin
    logic [32:0] rv;
    logic [31:0] exp_rd;
    logic        exp_il;
    if (cmp_en) begin
      rv     = m_read(bus.csr_addr);
      exp_rd = (!rst && bus.csr_en) ? rv[31:0] : 32'h0;
      exp_il = !rst && (bus.csr_en || bus.csr_we) &&
               (!rv[32] || (bus.csr_we && bus.csr_addr[11:10] == 2'b11) ||
                (bus.csr_op_sel == 2'b00));
      check("cmp_rdata", bus.csr_rdata, exp_rd);
      check("cmp_illegal", {31'b0, bus.csr_illegal}, {31'b0, exp_il});
      check("cmp_tohost", bus.tohost, m_tohost);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] rs1,
                       input logic ui = 1'b0, input logic [4:0] uimm = 5'h0);
    bus.csr_en       = en;
    bus.csr_we       = we;
    bus.csr_op_sel   = op;
    bus.csr_addr     = addr;
    bus.rs1_data     = rs1;
    bus.csr_ui       = ui;
    bus.csr_uimm     = uimm;
    bus.stall_ex     = 1'b0;
    bus.inst_retired = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    drive(1'b1, 1'b0, OP_RS, addr, 32'h0);
    #1;
    check(name, bus.csr_rdata, exp);
  endtask

  logic [11:0] addr_tab [16] = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h340, 12'h51E,
                                 12'h7FF, 12'h000, 12'h341, 12'hB03};

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, OP_RS, 12'h0, 32'h0);
    repeat (3) step();
    cmp_en = 1'b1;
    rst    = 1'b0;
    repeat (10) step();

    // Reset values and free-running cycle counter.
    rd_check("cycle_after_10", 12'hC00, 32'd10);
    step();
    rd_check("cycleh_reset", 12'hC80, 32'h0);
    rd_check("mscratch_reset", 12'h340, 32'h0);
    rd_check("tohost_reset", 12'h51E, TB_RESET_TOHOST);
    step();

    // mscratch RW / RSI / RC sequence.
    drive(1'b1, 1'b1, OP_RW, 12'h340, 32'hDEAD_BEEF); #1;
    check("csrrw_old", bus.csr_rdata, 32'h0);
    step();
    drive(1'b1, 1'b1, OP_RS, 12'h340, 32'h0, 1'b1, 5'h10); #1;
    check("csrrsi_old", bus.csr_rdata, 32'hDEAD_BEEF);
    step();
    drive(1'b1, 1'b1, OP_RC, 12'h340, 32'hFFFF_0000); #1;
    check("csrrc_old", bus.csr_rdata, 32'hDEAD_BEFF);
    step();
    rd_check("mscratch_after_rc", 12'h340, 32'h0000_BEFF);
    step();

    // CSRRWI tohost with rd=x0: write happens, rdata stays 0.
    drive(1'b0, 1'b1, OP_RW, 12'h51E, 32'h0, 1'b1, 5'h1); #1;
    check("rd_x0_rdata", bus.csr_rdata, 32'h0);
    step();
    check("tohost_written", bus.tohost, 32'h1);

    // Lo-half write then hi-half write; next increment carries into hi.
    drive(1'b0, 1'b1, OP_RW, 12'hB00, 32'hFFFF_FFFF); step();
    drive(1'b0, 1'b1, OP_RW, 12'hB80, 32'h0); step();
    rd_check("cycle_lo_held", 12'hC00, 32'hFFFF_FFFF);
    step();
    rd_check("cycle_carry_hi", 12'hC80, 32'h1);
    step();
    rd_check("cycle_carry_lo", 12'hC00, 32'h1);
    step();

    // Write beats same-cycle increment.
    drive(1'b0, 1'b1, OP_RW, 12'hB00, 32'h1234_0000); step();
    rd_check("write_beats_inc", 12'hC00, 32'h1234_0000);
    step();
    rd_check("hi_unchanged", 12'hC80, 32'h1);
    step();

    // Illegal accesses.
    drive(1'b1, 1'b1, OP_RW, 12'hC00, 32'h5); #1;
    check("ro_write_illegal", {31'b0, bus.csr_illegal}, 32'h1);
    step();
    rd_check("ro_write_dropped", 12'hC00, 32'h1234_0003);
    drive(1'b1, 1'b0, OP_RS, 12'h7FF, 32'h0); #1;
    check("unmapped_illegal", {31'b0, bus.csr_illegal}, 32'h1);
    check("unmapped_rdata", bus.csr_rdata, 32'h0);
    drive(1'b1, 1'b0, OP_RS, 12'hC00, 32'h0); #1;
    check("ro_read_legal", {31'b0, bus.csr_illegal}, 32'h0);
    step();

    // 64-bit wrap.
    drive(1'b0, 1'b1, OP_RW, 12'hB80, 32'hFFFF_FFFF); step();
    drive(1'b0, 1'b1, OP_RW, 12'hB00, 32'hFFFF_FFFF); step();
    rd_check("cycle_max_hi", 12'hC80, 32'hFFFF_FFFF);
    step();
    rd_check("cycle_wrap_hi", 12'hC80, 32'h0);
    step();

    // Stall blocks both write commit and instret increment.
    drive(1'b0, 1'b1, OP_RW, 12'hB02, 32'h7); step();
    drive(1'b0, 1'b1, OP_RW, 12'h340, 32'h55);
    bus.stall_ex = 1'b1; bus.inst_retired = 1'b1;
    step();
    rd_check("instret_stalled", 12'hC02, 32'h7);
    bus.inst_retired = 1'b1;
    step();
    rd_check("mscratch_stalled", 12'h340, 32'h0000_BEFF);
    rd_check("instret_inc", 12'hC02, 32'h8);
    step();

    // Reset mid-instruction discards the pending write.
    drive(1'b1, 1'b1, OP_RW, 12'h340, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_check("mscratch_rst", 12'h340, 32'h0);
    rd_check("cycle_rst", 12'hC00, 32'h0);
    rd_check("instret_rst", 12'hC02, 32'h0);
    check("tohost_rst", bus.tohost, TB_RESET_TOHOST);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 15)],
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      bus.stall_ex     = ($urandom_range(0, 3) == 0);
      bus.inst_retired = 1'($urandom_range(0, 1));
      rst              = ($urandom_range(0, 255) == 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, OP_RS, 12'h0, 32'h0);
    step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
